mem_bus_ctrl: RTL and testbench

//  Memory interface unit between the ARMv4 core's memory port (MAR/MRDR/MWDR/IR load path) and external RAM.

---
 rtl/mem_bus_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory interface unit: one core load/store -> one RAM transaction with lane enables and load alignment.
// Optional MEM_TIMEOUT_EN aborts an ACCESS that sees no mem_ack within TIMEOUT cycles.
module mem_bus_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        abort,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_cs,
    output logic        mem_we,
    output logic        mem_oe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic        lat_wr, lat_sign;
    logic [1:0]  lat_size, lat_off;
    logic        misalign, to_hit;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt, load_val;
    logic [63:0] rot;

    assign misalign = (size == 2'b01) && addr[0];

`ifdef MEM_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state == IDLE)
            to_cnt <= '0;
        else if (state == ACCESS && !mem_ack)
            to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Ack beats the terminal timeout count.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req && !misalign) state_nxt = ACCESS;
            ACCESS:  if (mem_ack)          state_nxt = DONE;
                     else if (to_hit)      state_nxt = IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_cs = (state == ACCESS);
    assign mem_we = mem_cs && lat_wr;
    assign mem_oe = mem_cs && !lat_wr;
    assign ready  = (state == DONE);
    assign busy   = (state == ACCESS) || (state == DONE);

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata;
        case (size)
            2'b00: begin
                be_nxt    = 4'b0001 << addr[1:0];
                wdata_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Byte/half loads pick their lane from the rotated word, so all sizes share one shifter.
    assign rot = {mem_rdata, mem_rdata} >> {lat_off, 3'b000};

    always_comb begin
        load_val = rot[31:0];
        case (lat_size)
            2'b00:   load_val = {{24{lat_sign && rot[7]}}, rot[7:0]};
            2'b01:   load_val = {{16{lat_sign && rot[15]}}, rot[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_wr    <= 1'b0;
            lat_sign  <= 1'b0;
            lat_size  <= 2'b00;
            lat_off   <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            rdata     <= '0;
            abort     <= 1'b0;
        end else begin
            abort <= ((state == IDLE) && req && misalign) ||
                     ((state == ACCESS) && !mem_ack && to_hit);
            if (state == IDLE && req && !misalign) begin
                lat_wr    <= wr;
                lat_sign  <= sign;
                lat_size  <= size;
                lat_off   <= addr[1:0];
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= wdata_nxt;
                mem_be    <= be_nxt;
            end
            if (state == ACCESS && mem_ack && !lat_wr)
                rdata <= load_val;
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: alignment, lane enables, latency, abort, reset and wait/timeout behaviour.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr, sign, mem_ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, mem_rdata;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        ready, busy, abort, mem_cs, mem_we, mem_oe;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
        .abort(abort), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction with `waits` ack-less ACCESS cycles; ready is due waits+2 cycles after req.
    task automatic xfer(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] md,
                        input int waits, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        wr = w; size = sz; sign = sg; addr = a; wdata = wd; req = 1'b1;
        tick();
        req = 1'b0;
        check({tag, " cs"}, {31'd0, mem_cs}, 32'd1);
        check({tag, " we"}, {31'd0, mem_we}, {31'd0, w});
        check({tag, " oe"}, {31'd0, mem_oe}, {31'd0, ~w});
        check({tag, " maddr"}, mem_addr, exp_addr);
        check({tag, " be"}, {28'd0, mem_be}, {28'd0, exp_be});
        if (w) check({tag, " mwdata"}, mem_wdata, exp_wdata);
        for (int i = 0; i < waits; i++) begin
            check({tag, " early ready"}, {31'd0, ready}, 32'd0);
            tick();
            check({tag, " wait busy"}, {31'd0, busy}, 32'd1);
        end
        mem_ack = 1'b1; mem_rdata = md;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check({tag, " ready"}, {31'd0, ready}, 32'd1);
        check({tag, " cs off"}, {31'd0, mem_cs}, 32'd0);
        check({tag, " rdata"}, rdata, exp_rdata);
        tick();
        check({tag, " ready pulse"}, {31'd0, ready}, 32'd0);
        check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b10; sign = 1'b0;
        addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        #1;
        check("rst rdata", rdata, 32'h0);
        check("rst maddr", mem_addr, 32'h0);
        check("rst mwdata", mem_wdata, 32'h0);
        check("rst ctrl", {26'd0, mem_be, ready, busy}, 32'h0);
        check("rst strobes", {28'd0, abort, mem_cs, mem_we, mem_oe}, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        xfer("ldr",     1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
        xfer("ldrsb",   1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80123456, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        xfer("ldrb",    1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80123456, 1, 32'h100, 4'b1000, 32'h0, 32'h00000080);
        xfer("ldr ror", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h11223344, 0, 32'h100, 4'b1111, 32'h0, 32'h33441122);
        xfer("strh",    1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 1, 32'h200, 4'b1100, 32'hABCDABCD, 32'h33441122);
        xfer("strb",    1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A, 32'h0, 0, 32'h100, 4'b0010, 32'h5A5A5A5A, 32'h33441122);
        xfer("ldrsh",   1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h80011234, 0, 32'h200, 4'b1100, 32'h0, 32'hFFFF8001);
        xfer("ldrh",    1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 32'h8001F234, 0, 32'h200, 4'b0011, 32'h0, 32'h0000F234);
        xfer("ldr sz3", 1'b0, 2'b11, 1'b0, 32'h301, 32'h0, 32'hAABBCCDD, 0, 32'h300, 4'b1111, 32'h0, 32'hDDAABBCC);

        // Misaligned halfword: abort pulse, never a chip select.
        wr = 1'b0; size = 2'b01; sign = 1'b0; addr = 32'h201; req = 1'b1;
        #1;
        check("mis cs pre", {31'd0, mem_cs}, 32'd0);
        tick();
        req = 1'b0;
        check("mis abort", {31'd0, abort}, 32'd1);
        check("mis cs", {31'd0, mem_cs}, 32'd0);
        check("mis busy", {31'd0, busy}, 32'd0);
        tick();
        check("mis abort pulse", {31'd0, abort}, 32'd0);
        check("mis cs after", {31'd0, mem_cs}, 32'd0);
        check("mis ready", {31'd0, ready}, 32'd0);

        // Load with no ack at all.
        wr = 1'b0; size = 2'b10; addr = 32'h400; req = 1'b1;
        tick();
        req = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            tick();
            check("to busy", {31'd0, busy}, 32'd1);
            check("to abort early", {31'd0, abort}, 32'd0);
        end
        tick();
        check("to abort", {31'd0, abort}, 32'd1);
        check("to busy off", {31'd0, busy}, 32'd0);
        check("to ready", {31'd0, ready}, 32'd0);
        check("to rdata kept", rdata, 32'hDDAABBCC);
        tick();
        check("to abort pulse", {31'd0, abort}, 32'd0);
`else
        repeat (100) tick();
        check("hang busy", {31'd0, busy}, 32'd1);
        check("hang cs", {31'd0, mem_cs}, 32'd1);
        check("hang abort", {31'd0, abort}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        // Reset in ACCESS: chip select drops without waiting for a clock.
        wr = 1'b0; size = 2'b10; addr = 32'h500; req = 1'b1;
        tick();
        req = 1'b0;
        check("rstx cs", {31'd0, mem_cs}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstx cs async", {31'd0, mem_cs}, 32'd0);
        check("rstx busy", {31'd0, busy}, 32'd0);
        check("rstx rdata", rdata, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        rst = 1'b0; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstx ready", {31'd0, ready}, 32'd0);
            check("rstx abort", {31'd0, abort}, 32'd0);
            tick();
        end
        check("rstx rdata hold", rdata, 32'h0);

        xfer("post rst", 1'b0, 2'b00, 1'b0, 32'h601, 32'h0, 32'h0000C300, 0, 32'h600, 4'b0010, 32'h0, 32'h000000C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
